// File: rtl/sb_pkg.sv
// Sideband shared definitions: link symbols, tx state codes, CRC helper.
package sb_pkg;

  // Link symbols, shared with the receive transactions FSM
  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;
  localparam logic [7:0] LSE     = 8'h80;
  localparam logic [7:0] CLSE    = 8'h7F;

  localparam logic [15:0] CRC_POLY = 16'h8005;

  // Transmit scheduler states
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_DISC  = 3'd0;
  localparam tx_state_t ST_IDLE  = 3'd1;
  localparam tx_state_t ST_HDR   = 3'd2;
  localparam tx_state_t ST_BODY  = 3'd3;
  localparam tx_state_t ST_STUFF = 3'd4;
  localparam tx_state_t ST_CRC   = 3'd5;
  localparam tx_state_t ST_TRAIL = 3'd6;
  localparam tx_state_t ST_GAP   = 3'd7;

  typedef enum logic [1:0] {
    REQ_LT  = 2'd0,
    REQ_RSP = 2'd1,
    REQ_CMD = 2'd2
  } req_kind_t;

  // Payload captured at grant; last = index of the final body byte
  typedef struct packed {
    req_kind_t   kind;
    logic [7:0]  addr;
    logic [7:0]  ctrl;
    logic [23:0] data;
    logic [2:0]  last;
  } tx_frame_t;

  // One byte of CRC-16 (poly 8005), MSB of the byte first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0000);
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_crc16.sv
// Byte-wide CRC-16 accumulator, reseeded on init.
module sb_crc16
  import sb_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  // Seed on init (wins over en), otherwise fold one byte per enabled cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc16_byte(crc, din);
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband transmit scheduler: arbitrates LT / AT response / AT command and
// emits the framed, DLE-stuffed byte stream over valid/ready.
module sb_tx_scheduler
  import sb_pkg::*;
#(
  parameter int          MIN_GAP  = 2,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
)(
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        disconnect,
  input  logic        lt_req,
  output logic        lt_ack,
  input  logic        rsp_req,
  input  logic [7:0]  rsp_addr,
  input  logic [23:0] rsp_rdata,
  output logic        rsp_ack,
  input  logic        cmd_req,
  input  logic [7:0]  cmd_addr,
  input  logic        cmd_write,
  input  logic [23:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [7:0]  sbtx_data,
  output logic        sbtx_valid,
  input  logic        sbtx_ready,
  output logic        busy,
  output logic        tx_abort
);

  tx_state_t   state;
  logic [2:0]  idx;        // byte position within the current state
  tx_frame_t   frm;
  logic        stuff_crc;  // the stuffed byte was a CRC byte
  logic [3:0]  gap_cnt;
  logic [7:0]  cur_byte;
  logic [15:0] crc;
  logic        take, is_fe, grant, crc_en;

  assign busy       = (state == ST_HDR) || (state == ST_BODY) || (state == ST_STUFF) ||
                      (state == ST_CRC) || (state == ST_TRAIL);
  assign sbtx_valid = busy;
  assign sbtx_data  = cur_byte;
  assign take       = sbtx_valid & sbtx_ready;
  assign is_fe      = (cur_byte == DLE);
  assign grant      = (state == ST_IDLE) & ~disconnect & (lt_req | rsp_req | cmd_req);

  // CRC covers STX and the unstuffed body bytes only
  assign crc_en = take & (frm.kind != REQ_LT) &
                  (((state == ST_HDR) && (idx == 3'd1)) || (state == ST_BODY));

  sb_crc16 #(.CRC_INIT(CRC_INIT)) u_crc (
    .clk  (sb_clk),
    .rst  (rst),
    .init (grant),
    .en   (crc_en),
    .din  (cur_byte),
    .crc  (crc)
  );

  // Byte currently presented to the serializer
  always_comb begin
    cur_byte = 8'h00;
    case (state)
      ST_HDR: begin
        if (idx == 3'd0)              cur_byte = DLE;
        else if (frm.kind == REQ_LT)  cur_byte = LSE;
        else if (frm.kind == REQ_RSP) cur_byte = STX_RSP;
        else                          cur_byte = STX_CMD;
      end
      ST_BODY: begin
        if (frm.kind == REQ_LT) cur_byte = CLSE;
        else begin
          case (idx)
            3'd0:    cur_byte = frm.addr;
            3'd1:    cur_byte = frm.ctrl;
            3'd2:    cur_byte = frm.data[7:0];
            3'd3:    cur_byte = frm.data[15:8];
            default: cur_byte = frm.data[23:16];
          endcase
        end
      end
      ST_STUFF: cur_byte = DLE;
      ST_CRC:   cur_byte = (idx == 3'd0) ? crc[7:0] : crc[15:8];
      ST_TRAIL: cur_byte = (idx == 3'd0) ? DLE : ETX;
      default:  cur_byte = 8'h00;
    endcase
  end

  // Frame sequencer; disconnect overrides every state and kills an open frame
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_DISC;
      idx       <= 3'd0;
      frm       <= '0;
      stuff_crc <= 1'b0;
      gap_cnt   <= 4'd0;
      lt_ack    <= 1'b0;
      rsp_ack   <= 1'b0;
      cmd_ack   <= 1'b0;
      tx_abort  <= 1'b0;
    end else begin
      lt_ack   <= 1'b0;
      rsp_ack  <= 1'b0;
      cmd_ack  <= 1'b0;
      tx_abort <= 1'b0;
      if (disconnect) begin
        state    <= ST_DISC;
        idx      <= 3'd0;
        tx_abort <= busy;
      end else begin
        case (state)
          ST_DISC: state <= ST_IDLE;

          ST_IDLE: begin
            idx <= 3'd0;
            if (lt_req) begin
              frm   <= '{kind: REQ_LT, addr: 8'h00, ctrl: 8'h00, data: 24'h0, last: 3'd0};
              state <= ST_HDR;
            end else if (rsp_req) begin
              frm   <= '{kind: REQ_RSP, addr: rsp_addr, ctrl: 8'h80, data: rsp_rdata, last: 3'd4};
              state <= ST_HDR;
            end else if (cmd_req) begin
              frm   <= '{kind: REQ_CMD, addr: cmd_addr, ctrl: {cmd_write, 7'd0},
                         data: cmd_wdata, last: (cmd_write ? 3'd4 : 3'd1)};
              state <= ST_HDR;
            end
          end

          ST_HDR: if (take) begin
            if (idx == 3'd0) idx <= 3'd1;
            else begin
              idx   <= 3'd0;
              state <= ST_BODY;
            end
          end

          ST_BODY: if (take) begin
            if (frm.kind == REQ_LT) begin
              lt_ack  <= 1'b1;
              gap_cnt <= 4'd0;
              state   <= ST_GAP;
            end else if (is_fe) begin
              stuff_crc <= 1'b0;
              state     <= ST_STUFF;
            end else if (idx == frm.last) begin
              idx   <= 3'd0;
              state <= ST_CRC;
            end else begin
              idx <= idx + 3'd1;
            end
          end

          // idx still points at the byte being duplicated
          ST_STUFF: if (take) begin
            if (stuff_crc) begin
              if (idx == 3'd0) begin
                idx   <= 3'd1;
                state <= ST_CRC;
              end else begin
                idx   <= 3'd0;
                state <= ST_TRAIL;
              end
            end else if (idx == frm.last) begin
              idx   <= 3'd0;
              state <= ST_CRC;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_BODY;
            end
          end

          ST_CRC: if (take) begin
            if (is_fe) begin
              stuff_crc <= 1'b1;
              state     <= ST_STUFF;
            end else if (idx == 3'd0) begin
              idx <= 3'd1;
            end else begin
              idx   <= 3'd0;
              state <= ST_TRAIL;
            end
          end

          ST_TRAIL: if (take) begin
            if (idx == 3'd0) idx <= 3'd1;
            else begin
              idx     <= 3'd0;
              gap_cnt <= 4'd0;
              state   <= ST_GAP;
              rsp_ack <= (frm.kind == REQ_RSP);
              cmd_ack <= (frm.kind == REQ_CMD);
            end
          end

          // MIN_GAP cycles here; the ack goes out in the first one
          ST_GAP: begin
            if (gap_cnt == 4'(MIN_GAP - 1)) begin
              gap_cnt <= 4'd0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end

          default: state <= ST_DISC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Bench for sb_tx_scheduler: directed and random frames against a byte-list model.
module tb_sb_tx_scheduler;
  localparam int MIN_GAP = 2;

  logic        sb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        disconnect = 1'b0;
  logic        lt_req = 1'b0, rsp_req = 1'b0, cmd_req = 1'b0, cmd_write = 1'b0;
  logic [7:0]  rsp_addr = 8'h00, cmd_addr = 8'h00;
  logic [23:0] rsp_rdata = 24'h0, cmd_wdata = 24'h0;
  logic        sbtx_ready = 1'b1;
  logic        lt_ack, rsp_ack, cmd_ack, sbtx_valid, busy, tx_abort;
  logic [7:0]  sbtx_data;

  sb_tx_scheduler #(.MIN_GAP(MIN_GAP), .CRC_INIT(16'hFFFF)) dut (
    .sb_clk(sb_clk), .rst(rst), .disconnect(disconnect),
    .lt_req(lt_req), .lt_ack(lt_ack),
    .rsp_req(rsp_req), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
    .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .sbtx_data(sbtx_data), .sbtx_valid(sbtx_valid),
    .sbtx_ready(sbtx_ready), .busy(busy), .tx_abort(tx_abort)
  );

  always #5 sb_clk = ~sb_clk;

  int errors = 0, checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int ack_log[$];
  int gaps[$];
  int busy_len[$];
  int n_abort = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  logic drop_lt = 1'b0, drop_rsp = 1'b0, drop_cmd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge will see
  initial begin : monitor
    int cyc, last_acc, busy_run, low_run;
    logic prev_stall;
    logic [7:0] prev_data;
    cyc = 0; last_acc = -10; busy_run = 0; low_run = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge sb_clk);
      cyc++;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, sbtx_valid}, 32'd1);
        chk("hold_data", {24'd0, sbtx_data}, {24'd0, prev_data});
      end
      prev_stall = sbtx_valid & ~sbtx_ready & ~disconnect & rst;
      prev_data  = sbtx_data;
      if (sbtx_valid && sbtx_ready) begin
        got.push_back(sbtx_data);
        last_acc = cyc;
      end
      if (lt_ack || rsp_ack || cmd_ack) begin
        ack_log.push_back(lt_ack ? 0 : (rsp_ack ? 1 : 2));
        chk("ack_latency", cyc - last_acc, 1);
      end
      if (tx_abort) n_abort++;
      if (busy) busy_run++;
      else if (busy_run > 0) begin busy_len.push_back(busy_run); busy_run = 0; end
      if (!sbtx_valid) low_run++;
      else if (low_run > 0) begin gaps.push_back(low_run); low_run = 0; end
    end
  end

  // One clock; requesters drop req the cycle after their ack; ready pattern
  task automatic step();
    @(posedge sb_clk);
    #1;
    if (drop_lt)  lt_req  = 1'b0;
    if (drop_rsp) rsp_req = 1'b0;
    if (drop_cmd) cmd_req = 1'b0;
    drop_lt = lt_ack; drop_rsp = rsp_ack; drop_cmd = cmd_ack;
    case (rdy_mode)
      0:       sbtx_ready = 1'b1;
      1:       sbtx_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
      default: sbtx_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_ph++;
  endtask

  // Reference: frame bytes in wire order from the frame format rules
  task automatic build(input int kind, input logic [7:0] addr, input logic wr, input logic [23:0] d);
    logic [7:0] pre[$];
    logic [7:0] b;
    logic [15:0] c;
    logic fb;
    if (kind == 0) begin
      exp_q.push_back(8'hFE); exp_q.push_back(8'h80); exp_q.push_back(8'h7F);
      return;
    end
    pre.push_back(kind == 1 ? 8'h04 : 8'h05);
    pre.push_back(addr);
    pre.push_back(kind == 1 ? 8'h80 : {wr, 7'd0});
    if (kind == 1 || wr) begin
      pre.push_back(d[7:0]); pre.push_back(d[15:8]); pre.push_back(d[23:16]);
    end
    c = 16'hFFFF;
    foreach (pre[k]) begin
      b = pre[k];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[j];
        c = c << 1;
        if (fb) c = c ^ 16'h8005;
      end
    end
    pre.push_back(c[7:0]);
    pre.push_back(c[15:8]);
    exp_q.push_back(8'hFE);
    exp_q.push_back(pre[0]);
    for (int k = 1; k < pre.size(); k++) begin
      exp_q.push_back(pre[k]);
      if (pre[k] == 8'hFE) exp_q.push_back(8'hFE);
    end
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h40);
  endtask

  task automatic issue(input int kind, input logic [7:0] addr, input logic wr, input logic [23:0] d);
    if (kind == 0) lt_req = 1'b1;
    else if (kind == 1) begin rsp_addr = addr; rsp_rdata = d; rsp_req = 1'b1; end
    else begin cmd_addr = addr; cmd_write = wr; cmd_wdata = d; cmd_req = 1'b1; end
  endtask

  task automatic wait_acks(input int target, input string tag);
    int n;
    n = 0;
    while (ack_log.size() < target && n < 3000) begin step(); n++; end
    chk({tag, "_ack_timeout"}, {31'd0, ack_log.size() >= target}, 32'd1);
  endtask

  task automatic wait_got(input int k, input string tag);
    int n;
    n = 0;
    while (got.size() < k && n < 3000) begin step(); n++; end
    chk({tag, "_byte_timeout"}, got.size(), k);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, {31'd0, sbtx_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    chk({tag, "_data"},  {24'd0, sbtx_data},  32'd0);
    chk({tag, "_acks"},  {29'd0, lt_ack, rsp_ack, cmd_ack}, 32'd0);
    chk({tag, "_abort"}, {31'd0, tx_abort},   32'd0);
  endtask

  initial begin : stim
    int base, flen, kind;
    logic [7:0] a;
    logic [23:0] d;
    #2 rst = 1'b0;
    step(); step();
    check_quiet("reset");
    rst = 1'b1;
    step();

    // Read command, ready high
    busy_len.delete();
    build(2, 8'h0C, 1'b0, 24'h0);
    flen = exp_q.size();
    issue(2, 8'h0C, 1'b0, 24'h0);
    wait_acks(1, "rd");
    chk("rd_busy_cycles", busy_len.size() > 0 ? busy_len[0] : 0, flen);
    chk("rd_ack_kind", ack_log[0], 2);
    check_frame("rd");
    step(); step(); step();

    // Write command with an FE data byte
    build(2, 8'h20, 1'b1, 24'h12FE34);
    issue(2, 8'h20, 1'b1, 24'h12FE34);
    wait_acks(2, "wr");
    check_frame("wr");
    step(); step(); step();

    // All three requesters at once: LT, then response, then command
    gaps.delete();
    base = ack_log.size();
    build(0, 8'h00, 1'b0, 24'h0);
    build(1, 8'hA5, 1'b0, 24'hC0FFEE);
    build(2, 8'h11, 1'b1, 24'h445566);
    issue(0, 8'h00, 1'b0, 24'h0);
    issue(1, 8'hA5, 1'b0, 24'hC0FFEE);
    issue(2, 8'h11, 1'b1, 24'h445566);
    wait_acks(base + 3, "prio");
    chk("prio_ack0", ack_log[base], 0);
    chk("prio_ack1", ack_log[base + 1], 1);
    chk("prio_ack2", ack_log[base + 2], 2);
    // valid-low cycles between frames: MIN_GAP gap cycles plus the grant cycle
    chk("prio_gaps", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("prio_gap1", gaps[1], MIN_GAP + 1);
      chk("prio_gap2", gaps[2], MIN_GAP + 1);
    end
    check_frame("prio");
    step(); step(); step();

    // Response with ready 1,0,0,1 repeating
    rdy_mode = 1;
    base = ack_log.size();
    build(1, 8'hFE, 1'b0, 24'hFE00FE);
    issue(1, 8'hFE, 1'b0, 24'hFE00FE);
    wait_acks(base + 1, "rdy");
    check_frame("rdy");
    step(); step(); step();

    // Random frames with random ready
    rdy_mode = 2;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
      for (int bi = 0; bi < 3; bi++)
        d[bi*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
      base = ack_log.size();
      build(kind, a, 1'($urandom_range(0, 1)) | (it[0]), d);
      issue(kind, a, 1'(it[0]) | exp_q.size() > 12, d);
      wait_acks(base + 1, "rand");
      chk("rand_kind", ack_log[base], kind);
      check_frame("rand");
      step(); step(); step();
    end

    // Disconnect on the 5th byte of a response
    rdy_mode = 0;
    step();
    base = ack_log.size();
    issue(1, 8'h3C, 1'b0, 24'hA1B2C3);
    wait_got(4, "disc");
    disconnect = 1'b1;
    step();
    chk("disc_abort", {31'd0, tx_abort}, 32'd1);
    chk("disc_valid", {31'd0, sbtx_valid}, 32'd0);
    chk("disc_busy", {31'd0, busy}, 32'd0);
    step();
    chk("disc_abort_pulse", {31'd0, tx_abort}, 32'd0);
    step(); step(); step();
    chk("disc_held_valid", {31'd0, sbtx_valid}, 32'd0);
    chk("disc_no_ack", ack_log.size(), base);
    chk("disc_abort_count", n_abort, 1);
    got.delete();
    build(1, 8'h3C, 1'b0, 24'hA1B2C3);
    disconnect = 1'b0;
    wait_acks(base + 1, "disc");
    check_frame("disc");
    step(); step(); step(); step();
    chk("disc_one_ack", ack_log.size(), base + 1);
    chk("disc_ack_kind", ack_log[base], 1);

    // Reset in the middle of the CRC bytes
    base = ack_log.size();
    issue(2, 8'h0C, 1'b0, 24'h0);
    wait_got(4, "rstmid");
    rst = 1'b0;
    #1;
    check_quiet("rstmid");
    step(); step();
    rst = 1'b1;
    got.delete();
    build(2, 8'h0C, 1'b0, 24'h0);
    wait_acks(base + 1, "rstmid");
    check_frame("rstmid");
    chk("final_abort_count", n_abort, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
